seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen.sv | 127 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with programmable length, repeat count and inter-repetition gap
module seq_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk_pulse,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       present_state
);
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] SEND = 3'b001;
  localparam logic [2:0] GAP  = 3'b010;
  localparam logic [2:0] DONE = 3'b011;
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [LEN_W-1:0] WLEN  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [GAP_W-1:0] ONE_G = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  // the pattern is stored left-aligned so the next bit is always the shifter's MSB
  logic [WIDTH-1:0] pat_q, sh_q, aligned;
  logic [LEN_W-1:0] len_q, idx_q, eff_len;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic             last_rep;
  always_comb begin
    eff_len  = (pat_len == '0 || pat_len > WLEN) ? WLEN : pat_len;
    aligned  = pattern << (WLEN - eff_len);
    last_rep = rep_q == ONE_C;
  end
  assign busy = (present_state == SEND) || (present_state == GAP);
  always_ff @(posedge clk_pulse or posedge clear) begin
    if (clear) begin
      present_state <= IDLE;
      ser_out       <= 1'b0;
      ser_valid     <= 1'b0;
      done          <= 1'b0;
      pat_q         <= '0;
      sh_q          <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
    end else begin
      case (present_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat_q         <= aligned;
            sh_q          <= aligned << 1;
            len_q         <= eff_len;
            idx_q         <= eff_len - ONE_L;
            rep_q         <= repeat_cnt;
            ser_out       <= aligned[WIDTH-1];
            ser_valid     <= 1'b1;
            present_state <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            present_state <= IDLE;
            ser_out       <= 1'b0;
            ser_valid     <= 1'b0;
          end else if (idx_q != '0) begin
            idx_q   <= idx_q - ONE_L;
            ser_out <= sh_q[WIDTH-1];
            sh_q    <= sh_q << 1;
          end else if (last_rep) begin
            present_state <= DONE;
            ser_out       <= 1'b0;
            ser_valid     <= 1'b0;
            done          <= 1'b1;
          end else begin
            // a zero count means continuous mode, so it is never decremented
            rep_q <= (rep_q == '0) ? rep_q : rep_q - ONE_C;
            if (GAP_CYCLES > 0) begin
              present_state <= GAP;
              ser_out       <= 1'b0;
              ser_valid     <= 1'b0;
              gap_q         <= GAP_LOAD;
            end else begin
              idx_q   <= len_q - ONE_L;
              ser_out <= pat_q[WIDTH-1];
              sh_q    <= pat_q << 1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            present_state <= IDLE;
            ser_out       <= 1'b0;
            ser_valid     <= 1'b0;
          end else if (gap_q != '0) begin
            gap_q <= gap_q - ONE_G;
          end else begin
            present_state <= SEND;
            idx_q         <= len_q - ONE_L;
            ser_out       <= pat_q[WIDTH-1];
            ser_valid     <= 1'b1;
            sh_q          <= pat_q << 1;
          end
        end
        DONE: begin
          done          <= 1'b0;
          present_state <= IDLE;
        end
        default: begin
          present_state <= IDLE;
          ser_out       <= 1'b0;
          ser_valid     <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed bench for seq_pattern_gen with back-to-back and gapped instances
module tb_seq_pattern_gen;
  logic       clk_pulse = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic [3:0] repeat_cnt = '0;
  logic       so0, sv0, b0, d0, so2, sv2, b2, d2;
  logic [2:0] st0, st2;
  int tests = 0;
  int fails = 0;

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP_CYCLES(0)) u0 (
    .clk_pulse(clk_pulse), .clear(clear), .start(start), .abort(abort),
    .pattern(pattern), .pat_len(pat_len), .repeat_cnt(repeat_cnt),
    .ser_out(so0), .ser_valid(sv0), .busy(b0), .done(d0), .present_state(st0));

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP_CYCLES(2)) u2 (
    .clk_pulse(clk_pulse), .clear(clear), .start(start), .abort(abort),
    .pattern(pattern), .pat_len(pat_len), .repeat_cnt(repeat_cnt),
    .ser_out(so2), .ser_valid(sv2), .busy(b2), .done(d2), .present_state(st2));

  always #5 clk_pulse = ~clk_pulse;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_pulse);
    #1;
  endtask

  task automatic reset_all;
    start = 1'b0;
    abort = 1'b0;
    clear = 1'b1;
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset;
    #1 clear = 1'b1;
    start = 1'b1; pattern = 8'hFF; pat_len = 4'd3; repeat_cnt = 4'd1;
    #3 pattern = 8'h55; start = 1'b0;
    #3 start = 1'b1; abort = 1'b1;
    #4;
    tests++; if ({so0, sv0, b0, d0, st0} !== 7'b0) begin fails++; $display("FAIL reset_u0 got %b exp 0000000", {so0, sv0, b0, d0, st0}); end
    tests++; if ({so2, sv2, b2, d2, st2} !== 7'b0) begin fails++; $display("FAIL reset_u2 got %b exp 0000000", {so2, sv2, b2, d2, st2}); end
    start = 1'b0; abort = 1'b0; clear = 1'b0;
    tick;
    pattern = 8'hFF; pat_len = 4'd8; repeat_cnt = 4'd1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tests++; if ({so0, sv0, b0, st0} !== 6'b111001) begin fails++; $display("FAIL midsend_pre got %b exp 111001", {so0, sv0, b0, st0}); end
    clear = 1'b1;
    #1;
    tests++; if ({so0, sv0, b0, d0, st0} !== 7'b0) begin fails++; $display("FAIL async_clear got %b exp 0000000", {so0, sv0, b0, d0, st0}); end
    clear = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [11:0] stream;
    logic [2:0]  hist;
    int c11, c110;
    reset_all;
    tick;
    pattern = 8'b0000_0011; pat_len = 4'd3; repeat_cnt = 4'd4; start = 1'b1;
    tick;
    start = 1'b0;
    stream = '0; hist = '0; c11 = 0; c110 = 0;
    for (int i = 0; i < 12; i++) begin
      tests++; if ({sv0, b0, st0} !== 5'b11001) begin fails++; $display("FAIL b2b_valid%0d got %b exp 11001", i, {sv0, b0, st0}); end
      stream = {stream[10:0], so0};
      hist = {hist[1:0], so0};
      if (hist[1:0] == 2'b11) c11++;
      if (hist == 3'b110) c110++;
      tick;
    end
    tests++; if (stream !== 12'b011011011011) begin fails++; $display("FAIL b2b_stream got %b exp 011011011011", stream); end
    tests++; if (c11 !== 4) begin fails++; $display("FAIL det_11 got %0d exp 4", c11); end
    tests++; if (c110 !== 3) begin fails++; $display("FAIL det_110 got %0d exp 3", c110); end
    tests++; if ({d0, sv0, b0, st0} !== 6'b100011) begin fails++; $display("FAIL b2b_done got %b exp 100011", {d0, sv0, b0, st0}); end
    tick;
    tests++; if ({d0, st0} !== 4'b0000) begin fails++; $display("FAIL b2b_idle got %b exp 0000", {d0, st0}); end
  endtask

  task automatic test_gap;
    logic [8:0] eo, ev, eb, ed;
    logic [2:0] es [9];
    eo = 9'b101001010; ev = 9'b111001110; eb = 9'b111111110; ed = 9'b000000001;
    es = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd3};
    reset_all;
    tick;
    pattern = 8'b0000_0101; pat_len = 4'd3; repeat_cnt = 4'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tests++;
      if ({so2, sv2, b2, d2, st2} !== {eo[8-i], ev[8-i], eb[8-i], ed[8-i], es[i]}) begin
        fails++;
        $display("FAIL gap_cycle%0d got %b exp %b", i, {so2, sv2, b2, d2, st2}, {eo[8-i], ev[8-i], eb[8-i], ed[8-i], es[i]});
      end
      tick;
    end
    tests++; if ({d2, st2} !== 4'b0000) begin fails++; $display("FAIL gap_idle got %b exp 0000", {d2, st2}); end
  endtask

  task automatic test_length;
    logic [7:0] e;
    e = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      reset_all;
      tick;
      pattern = 8'hA5; pat_len = (k == 0) ? 4'd0 : 4'd12; repeat_cnt = 4'd1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tests++; if ({so0, sv0} !== {e[7-i], 1'b1}) begin fails++; $display("FAIL len%0d_bit%0d got %b exp %b", k, i, {so0, sv0}, {e[7-i], 1'b1}); end
        tick;
      end
      tests++; if ({d0, sv0, st0} !== 5'b10011) begin fails++; $display("FAIL len%0d_done got %b exp 10011", k, {d0, sv0, st0}); end
    end
    reset_all;
    tick;
    pattern = 8'b0000_0001; pat_len = 4'd1; repeat_cnt = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({so0, sv0, st0} !== 5'b11001) begin fails++; $display("FAIL len1_bit%0d got %b exp 11001", i, {so0, sv0, st0}); end
      tick;
    end
    tests++; if ({d0, sv0, st0} !== 5'b10011) begin fails++; $display("FAIL len1_done got %b exp 10011", {d0, sv0, st0}); end
  endtask

  task automatic test_continuous_abort;
    reset_all;
    tick;
    pattern = 8'b0000_0010; pat_len = 4'd2; repeat_cnt = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tests++; if ({so0, sv0} !== {(i % 2 == 0), 1'b1}) begin fails++; $display("FAIL cont_bit%0d got %b exp %b", i, {so0, sv0}, {(i % 2 == 0), 1'b1}); end
      if (i < 6) tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tests++; if ({so0, sv0, b0, d0, st0} !== 7'b0) begin fails++; $display("FAIL abort_idle got %b exp 0000000", {so0, sv0, b0, d0, st0}); end
    tick;
    tests++; if ({d0, st0} !== 4'b0000) begin fails++; $display("FAIL abort_nodone got %b exp 0000", {d0, st0}); end
  endtask

  task automatic test_isolation;
    logic [5:0] e;
    e = 6'b110110;
    reset_all;
    tick;
    pattern = 8'b0000_0110; pat_len = 4'd3; repeat_cnt = 4'd2; start = 1'b1;
    tick;
    pattern = 8'hFF; pat_len = 4'd5; repeat_cnt = 4'd7;
    for (int i = 0; i < 6; i++) begin
      tests++; if ({so0, sv0} !== {e[5-i], 1'b1}) begin fails++; $display("FAIL iso_bit%0d got %b exp %b", i, {so0, sv0}, {e[5-i], 1'b1}); end
      tick;
    end
    tests++; if ({d0, st0} !== 4'b1011) begin fails++; $display("FAIL iso_done got %b exp 1011", {d0, st0}); end
    tick;
    tests++; if ({d0, sv0, st0} !== 5'b00000) begin fails++; $display("FAIL iso_idle got %b exp 00000", {d0, sv0, st0}); end
    tick;
    tests++; if ({so0, sv0, st0} !== 5'b11001) begin fails++; $display("FAIL iso_restart got %b exp 11001", {so0, sv0, st0}); end
    reset_all;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gap;
    test_length;
    test_continuous_abort;
    test_isolation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
